tone_sequencer: RTL

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/tone_seq_pkg.sv | 17 +
 rtl/tone_channel.sv | 145 ++++++++++++++
 rtl/tone_sequencer.sv | 71 +++++++
 3 files changed

// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: register map, STATUS/CTRL bit positions and channel state shared by tone_sequencer.
package tone_seq_pkg;
    localparam logic [1:0] REG_NOTE   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PEND  = 4;
    localparam int ST_LEVEL = 8;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_IRQ_CLR = 3;
    typedef enum logic {IDLE, PLAY} ch_state_e;
endpackage

// File: rtl/tone_channel.sv
// tone_channel: one note FIFO feeding a duration prescaler and a half-period divider
// that drives a differential {left,right} buzzer pair.
module tone_channel
    import tone_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 400_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [31:0] note_i,
    input  logic        ctrl_we_i,
    input  logic [3:0]  ctrl_i,
    input  logic        status_rd_i,
    output logic [31:0] status_o,
    output logic [31:0] ctrl_o,
    output logic [1:0]  tone_o,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TICK_DIV + 1);

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [LW-1:0] level_q, level_d;
    ch_state_e     state_q, state_d;
    logic [15:0]   freq_q, freq_d, dur_q, dur_d, dur_cnt_q, dur_cnt_d, half_q, half_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          phase_q, phase_d, enable_q, enable_d, irq_en_q, irq_en_d;
    logic          ovf_q, ovf_d, pend_q, pend_d;
    logic [1:0]    tone_q, tone_d;
    logic          flush, empty, full, pop, push_ok, note_end, tick_wrap;
    logic [31:0]   head;

    assign head      = mem_q[rptr_q];
    assign empty     = level_q == '0;
    assign full      = level_q == LW'(FIFO_DEPTH);
    assign flush     = ctrl_we_i && ctrl_i[CTRL_FLUSH];
    assign tick_wrap = tick_q == TW'(TICK_DIV - 1);
    assign note_end  = tick_wrap && dur_cnt_q == dur_q - 16'd1;

    always_comb begin
        state_d   = state_q;
        freq_d    = freq_q;
        dur_d     = dur_q;
        dur_cnt_d = dur_cnt_q;
        half_d    = half_q;
        tick_d    = tick_q;
        phase_d   = phase_q;
        enable_d  = ctrl_we_i ? ctrl_i[CTRL_EN] : enable_q;
        irq_en_d  = ctrl_we_i ? ctrl_i[CTRL_IRQ_EN] : irq_en_q;
        pend_d    = pend_q && !(ctrl_we_i && ctrl_i[CTRL_IRQ_CLR]);
        pop       = 1'b0;
        if (state_q == IDLE || (enable_q && note_end)) begin
            pop = enable_q && !empty;
            if (pop) begin
                state_d   = PLAY;
                freq_d    = head[31:16];
                dur_d     = head[15:0];
                dur_cnt_d = '0;
                half_d    = '0;
                tick_d    = '0;
                phase_d   = 1'b1;
            end else if (state_q == PLAY) begin
                state_d = IDLE;
                pend_d  = 1'b1;
            end
        end else if (enable_q) begin
            tick_d    = tick_wrap ? '0 : tick_q + TW'(1);
            dur_cnt_d = tick_wrap ? dur_cnt_q + 16'd1 : dur_cnt_q;
            half_d    = (half_q == freq_q) ? '0 : half_q + 16'd1;
            phase_d   = (half_q == freq_q) ? !phase_q : phase_q;
        end
        // a flush abandons the note silently: no pop, no pending from a same-cycle note end
        if (flush) begin
            state_d = IDLE;
            pop     = 1'b0;
            pend_d  = pend_q && !ctrl_i[CTRL_IRQ_CLR];
        end
        push_ok = push_i && !flush && note_i[15:0] != '0 && (!full || pop);
        ovf_d   = (ovf_q && !status_rd_i) || (push_i && !flush && note_i[15:0] != '0 && full && !pop);
        rptr_d  = flush ? '0 : rptr_q + AW'(pop);
        wptr_d  = flush ? '0 : wptr_q + AW'(push_ok);
        level_d = flush ? '0 : level_q + LW'(push_ok) - LW'(pop);
        tone_d  = (state_d == PLAY && enable_d && freq_d != '0) ? (phase_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rptr_q    <= '0;
            wptr_q    <= '0;
            level_q   <= '0;
            freq_q    <= '0;
            dur_q     <= '0;
            dur_cnt_q <= '0;
            half_q    <= '0;
            tick_q    <= '0;
            phase_q   <= 1'b0;
            enable_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            pend_q    <= 1'b0;
            tone_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            level_q   <= level_d;
            freq_q    <= freq_d;
            dur_q     <= dur_d;
            dur_cnt_q <= dur_cnt_d;
            half_q    <= half_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            enable_q  <= enable_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            pend_q    <= pend_d;
            tone_q    <= tone_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= note_i;
    end

    always_comb begin
        status_o                  = '0;
        status_o[ST_BUSY]         = state_q == PLAY;
        status_o[ST_FULL]         = full;
        status_o[ST_EMPTY]        = empty;
        status_o[ST_OVF]          = ovf_q;
        status_o[ST_PEND]         = pend_q;
        status_o[ST_LEVEL +: 7]   = 7'(level_q);
        ctrl_o                    = '0;
        ctrl_o[CTRL_EN]           = enable_q;
        ctrl_o[CTRL_IRQ_EN]       = irq_en_q;
    end

    assign tone_o = tone_q;
    assign irq_o  = pend_q && irq_en_q;
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: bus front end for N_CH tone channels -- address decode, registered
// read mux and registered interrupt OR.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 400_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [7:0]        address_i,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic [2*N_CH-1:0] tone_o,
    output logic              irq_o
);
    logic [31:0]     status [N_CH];
    logic [31:0]     ctrl [N_CH];
    logic [N_CH-1:0] irq_vec;
    logic [31:0]     rdata, data_out_q, data_out_d;
    logic            irq_q, irq_d, wr, rd, unused_addr;
    logic [3:0]      ch_sel;
    logic [1:0]      reg_sel;

    assign ch_sel      = address_i[7:4];
    assign reg_sel     = address_i[3:2];
    assign wr          = cs_i && write_i;
    assign rd          = cs_i && read_i;
    assign unused_addr = ^address_i[1:0];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tone_channel #(.FIFO_DEPTH(FIFO_DEPTH), .TICK_DIV(TICK_DIV)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .push_i     (wr && ch_sel == 4'(i) && reg_sel == REG_NOTE),
            .note_i     (data_in),
            .ctrl_we_i  (wr && ch_sel == 4'(i) && reg_sel == REG_CTRL),
            .ctrl_i     (data_in[3:0]),
            .status_rd_i(rd && ch_sel == 4'(i) && reg_sel == REG_STATUS),
            .status_o   (status[i]),
            .ctrl_o     (ctrl[i]),
            .tone_o     (tone_o[2*i +: 2]),
            .irq_o      (irq_vec[i])
        );
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < N_CH; j++)
            if (ch_sel == 4'(j)) rdata = reg_sel == REG_STATUS ? status[j] : reg_sel == REG_CTRL ? ctrl[j] : '0;
        data_out_d = rd ? rdata : data_out_q;
        irq_d      = |irq_vec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            irq_q      <= irq_d;
        end
    end

    assign data_out = data_out_q;
    assign irq_o    = irq_q;
endmodule
